// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared widths, defaults, capture states and CRC helper for video_capture
package video_pkg;

    localparam int ADDR_W        = 14;
    localparam int RGB_W         = 12;
    localparam int CNT_W         = 12;
    localparam int PH_W          = 8;
    localparam int FB_WIDTH_DEF  = 128;
    localparam int FB_HEIGHT_DEF = 96;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // CRC-16-CCITT over one pixel, zero-extended to 16 bits, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [RGB_W-1:0] data);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = crc;
        d = {{(16-RGB_W){1'b0}}, data};
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// rtl/video_sync_counter.sv - input register stage, sync edge detect, h/v counters and sample flag
module video_sync_counter
    import video_pkg::*;
#(
    parameter int FB_WIDTH        = FB_WIDTH_DEF,
    parameter int FB_HEIGHT       = FB_HEIGHT_DEF,
    parameter int H_START         = 144,
    parameter int V_START         = 35,
    parameter int H_DECIM         = 5,
    parameter int V_DECIM         = 5,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RGB_W-1:0] video_rgb,
    input  logic             video_hsync,
    input  logic             video_vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             h_edge,
    output logic             v_edge,
    output logic             sample
);

    localparam logic             SYNC_LVL = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [CNT_W-1:0] H_LO     = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI     = CNT_W'(H_START + FB_WIDTH * H_DECIM);
    localparam logic [CNT_W-1:0] V_LO     = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI     = CNT_W'(V_START + FB_HEIGHT * V_DECIM);
    localparam logic [PH_W-1:0]  H_PH_MAX = PH_W'(H_DECIM - 1);
    localparam logic [PH_W-1:0]  V_PH_MAX = PH_W'(V_DECIM - 1);

    logic [RGB_W-1:0] rgb_q;
    logic             hs_q, vs_q, hs_prev, vs_prev;
    logic [CNT_W-1:0] hcnt_q, vcnt_q, hcnt_cur, vcnt_cur;
    logic [PH_W-1:0]  hph_q, vph_q, hph_cur, vph_cur;
    logic             h_act, v_act;

    assign rgb    = rgb_q;
    assign h_edge = (hs_q == SYNC_LVL) && (hs_prev != SYNC_LVL);
    assign v_edge = (vs_q == SYNC_LVL) && (vs_prev != SYNC_LVL);

    // Counts describe the pixel currently held in the input register.
    always_comb begin
        hcnt_cur = h_edge ? '0 : ((&hcnt_q) ? hcnt_q : hcnt_q + CNT_W'(1));
        vcnt_cur = vcnt_q;
        if (v_edge)      vcnt_cur = '0;
        else if (h_edge) vcnt_cur = (&vcnt_q) ? vcnt_q : vcnt_q + CNT_W'(1);

        if (hcnt_cur == H_LO)      hph_cur = '0;
        else if (hph_q == H_PH_MAX) hph_cur = '0;
        else                       hph_cur = hph_q + PH_W'(1);

        vph_cur = vph_q;
        if (h_edge || v_edge) begin
            if (vcnt_cur == V_LO)       vph_cur = '0;
            else if (vph_q == V_PH_MAX) vph_cur = '0;
            else                        vph_cur = vph_q + PH_W'(1);
        end

        h_act  = (hcnt_cur >= H_LO) && (hcnt_cur < H_HI);
        v_act  = (vcnt_cur >= V_LO) && (vcnt_cur < V_HI);
        sample = h_act && v_act && (hph_cur == '0) && (vph_cur == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hph_q   <= '0;
            vph_q   <= '0;
        end else begin
            rgb_q   <= video_rgb;
            hs_q    <= video_hsync;
            vs_q    <= video_vsync;
            hs_prev <= hs_q;
            vs_prev <= vs_q;
            hcnt_q  <= hcnt_cur;
            vcnt_q  <= vcnt_cur;
            hph_q   <= hph_cur;
            vph_q   <= vph_cur;
        end
    end

endmodule

// File: rtl/video_capture.sv
// rtl/video_capture.sv - frame capture FSM and memory write port; VIDEO_CAPTURE_CRC_EN adds frame_crc
module video_capture
    import video_pkg::*;
#(
    parameter int FB_WIDTH        = FB_WIDTH_DEF,
    parameter int FB_HEIGHT       = FB_HEIGHT_DEF,
    parameter int H_START         = 144,
    parameter int V_START         = 35,
    parameter int H_DECIM         = 5,
    parameter int V_DECIM         = 5,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_start,
    input  logic [RGB_W-1:0]  video_rgb,
    input  logic              video_hsync,
    input  logic              video_vsync,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RGB_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame
`ifdef VIDEO_CAPTURE_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    localparam logic [ADDR_W-1:0] FBW_A = ADDR_W'(FB_WIDTH);
    localparam logic [ADDR_W-1:0] FBH_A = ADDR_W'(FB_HEIGHT);

    generate
        if (FB_WIDTH * FB_HEIGHT > (1 << ADDR_W)) begin : g_size_check
            $error("FB_WIDTH*FB_HEIGHT exceeds the 16K video memory");
        end
    endgenerate

    cap_state_t        state, state_d;
    logic [ADDR_W-1:0] row, row_d, col, col_d, addr_d;
    logic [RGB_W-1:0]  data_d, rgb;
    logic              row_hit, row_hit_d, short_d, we_d;
    logic              h_edge, v_edge, sample;

    video_sync_counter #(
        .FB_WIDTH       (FB_WIDTH),
        .FB_HEIGHT      (FB_HEIGHT),
        .H_START        (H_START),
        .V_START        (V_START),
        .H_DECIM        (H_DECIM),
        .V_DECIM        (V_DECIM),
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .video_rgb  (video_rgb),
        .video_hsync(video_hsync),
        .video_vsync(video_vsync),
        .rgb        (rgb),
        .h_edge     (h_edge),
        .v_edge     (v_edge),
        .sample     (sample)
    );

    assign busy       = (state == ARMED) || (state == CAPTURE);
    assign frame_done = (state == DONE);

    always_comb begin
        state_d   = state;
        row_d     = row;
        col_d     = col;
        row_hit_d = row_hit;
        short_d   = short_frame;
        we_d      = 1'b0;
        addr_d    = wr_addr;
        data_d    = wr_data;
        case (state)
            IDLE: begin
                if (capture_start) begin
                    state_d = ARMED;
                    short_d = 1'b0;
                end
            end
            ARMED: begin
                if (v_edge) begin
                    state_d   = CAPTURE;
                    row_d     = '0;
                    col_d     = '0;
                    row_hit_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (v_edge) begin
                    state_d = DONE;
                    short_d = 1'b1;
                end else if (h_edge) begin
                    // A short line simply ends the row; unwritten columns stay untouched.
                    if (row_hit) begin
                        row_d     = row + ADDR_W'(1);
                        col_d     = '0;
                        row_hit_d = 1'b0;
                    end
                end else if (sample && (col < FBW_A) && (row < FBH_A)) begin
                    we_d      = 1'b1;
                    addr_d    = row * FBW_A + col;
                    data_d    = rgb;
                    col_d     = col + ADDR_W'(1);
                    row_hit_d = 1'b1;
                    if ((row == FBH_A - ADDR_W'(1)) && (col == FBW_A - ADDR_W'(1)))
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            row_hit     <= 1'b0;
            short_frame <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            state       <= state_d;
            row         <= row_d;
            col         <= col_d;
            row_hit     <= row_hit_d;
            short_frame <= short_d;
            wr_en       <= we_d;
            wr_addr     <= addr_d;
            wr_data     <= data_d;
        end
    end

`ifdef VIDEO_CAPTURE_CRC_EN
    logic [15:0] crc;
    logic        accept;

    assign accept    = (state == IDLE) && capture_start;
    assign frame_crc = crc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        crc <= CRC_INIT;
        else if (accept) crc <= CRC_INIT;
        else if (we_d)   crc <= crc16_word(crc, data_d);
    end
`endif

endmodule

// File: tb/tb_video_capture.sv
// tb/tb_video_capture.sv - scoreboard bench for video_capture on a scaled-down video timing
module tb_video_capture;

    localparam int FBW = 16, FBH = 8, HS = 12, VS = 4, HD = 3, VD = 2;
    localparam int H_TOTAL = 70, HS_W = 4, VS_W = 2, N_LINES = 23;

    logic        clk = 1'b0, rst = 1'b0, capture_start = 1'b0;
    logic [11:0] video_rgb = '0;
    logic        video_hsync = 1'b1, video_vsync = 1'b1;
    logic [13:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en, busy, frame_done, short_frame;
`ifdef VIDEO_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
    logic [15:0] crc_model = 16'hFFFF;
`endif

    video_capture #(
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .H_START(HS), .V_START(VS),
        .H_DECIM(HD), .V_DECIM(VD), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .capture_start(capture_start),
        .video_rgb(video_rgb), .video_hsync(video_hsync), .video_vsync(video_vsync),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
        .frame_done(frame_done), .short_frame(short_frame)
`ifdef VIDEO_CAPTURE_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0, done_cnt = 0;
    int n_lines, cut_v, cut_len, start_v, start_h, rst_v, rst_h;
    bit cap_this, exp_short, prev_done;
    logic [11:0] seed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

`ifdef VIDEO_CAPTURE_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input int d);
        logic [15:0] r;
        logic [15:0] w;
        r = c;
        w = 16'(d);
        for (int i = 15; i >= 0; i--) begin
            r = (r[15] ^ w[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    always @(negedge clk) begin
        exp_t e;
        if (prev_done) check("busy_after_done", 32'(busy), 0);
        prev_done = frame_done;
        if (wr_en) begin
            if (sb.size() == 0) begin
                check("extra_wr_en", 32'(wr_en), 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), e.addr);
                check("wr_data", 32'(wr_data), e.data);
                check("wr_latency", cyc, e.cyc);
`ifdef VIDEO_CAPTURE_CRC_EN
                crc_model = crc_ref(crc_model, e.data);
`endif
            end
        end
        if (frame_done) begin
            done_cnt++;
            check("short_frame", 32'(short_frame), 32'(exp_short));
            check("sb_drained_at_done", sb.size(), 0);
`ifdef VIDEO_CAPTURE_CRC_EN
            check("frame_crc", 32'(frame_crc), 32'(crc_model));
            crc_model = 16'hFFFF;
`endif
        end
    end

    task automatic drive_frame();
        for (int v = 0; v < n_lines; v++) begin
            int len;
            len = (v == cut_v) ? cut_len : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                logic [11:0] pix;
                @(negedge clk);
                if (!rst) rst = 1'b1;
                pix = {v[5:0], h[5:0]} ^ seed;
                video_rgb     = pix;
                video_hsync   = (h < HS_W) ? 1'b0 : 1'b1;
                video_vsync   = (v < VS_W) ? 1'b0 : 1'b1;
                capture_start = (v == start_v) && (h == start_h);
                if (cap_this && h >= HS && h < HS + FBW*HD && (h - HS) % HD == 0 &&
                    v >= VS && v < VS + FBH*VD && (v - VS) % VD == 0)
                    sb.push_back('{((v - VS) / VD) * FBW + (h - HS) / HD, int'(pix), cyc + 2});
                if (v == rst_v && h == rst_h) begin
                    check("pre_rst_wr_en", 32'(wr_en), 1);
                    #2 rst = 1'b0;
                    #1;
                    check("rst_wr_en", 32'(wr_en), 0);
                    check("rst_busy", 32'(busy), 0);
                    check("rst_frame_done", 32'(frame_done), 0);
                    sb.delete();
                    cap_this = 1'b0;
`ifdef VIDEO_CAPTURE_CRC_EN
                    crc_model = 16'hFFFF;
`endif
                end
            end
        end
        @(negedge clk);
        capture_start = 1'b0;
    endtask

    initial begin
        n_lines = N_LINES; cut_v = -1; cut_len = 0; start_v = -1; start_h = 0;
        rst_v = -1; rst_h = 0; cap_this = 0; exp_short = 0; prev_done = 0; seed = '0;
        repeat (3) @(negedge clk);
        check("reset_wr_addr", 32'(wr_addr), 0);
        check("reset_wr_data", 32'(wr_data), 0);
        check("reset_wr_en", 32'(wr_en), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_short_frame", 32'(short_frame), 0);
        rst = 1'b1;

        // A: idle frame with a start request partway through
        start_v = 10; start_h = 5;
        drive_frame();
        check("armed_busy", 32'(busy), 1);
        start_v = -1;

        // B: full capture
        cap_this = 1; seed = 12'h000;
        drive_frame();
        cap_this = 0;
        check("done_after_b", done_cnt, 1);
        check("idle_after_b", 32'(busy), 0);

        // C: start coincident with the detected vsync edge; this frame is not captured
        start_v = 0; start_h = 1;
        drive_frame();
        start_v = -1;
        check("done_after_c", done_cnt, 1);
        check("armed_after_c", 32'(busy), 1);

        // D: row 3 cut after 10 columns, plus an ignored start mid-capture
        cap_this = 1; seed = 12'h5A5; start_v = 9; start_h = 30;
        cut_v = VS + 3*VD; cut_len = HS + 10*HD;
        drive_frame();
        cap_this = 0; cut_v = -1; start_v = -1;
        check("done_after_d", done_cnt, 2);

        // E: must produce no writes; arm for F at the end
        start_v = 21; start_h = 0;
        drive_frame();
        check("done_after_e", done_cnt, 2);
        check("armed_after_e", 32'(busy), 1);

        // F: vsync arrives after row 5
        cap_this = 1; start_v = -1; seed = 12'h333; n_lines = VS + 6*VD - 1;
        drive_frame();
        cap_this = 0; n_lines = N_LINES; exp_short = 1;

        // G: its vsync ends F early; re-arm late in the frame
        start_v = 20; start_h = 0;
        drive_frame();
        start_v = -1;
        check("done_after_g", done_cnt, 3);
        check("short_cleared_by_start", 32'(short_frame), 0);

        // No sync activity while armed
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            video_hsync = 1'b1; video_vsync = 1'b1; video_rgb = 12'($urandom);
        end
        check("armed_hold_busy", 32'(busy), 1);
        exp_short = 0;

        // H: reset during capture of row 4
        cap_this = 1; seed = 12'h0F0; rst_v = VS + 4*VD; rst_h = HS + 2;
        drive_frame();
        rst_v = -1; cap_this = 0;
        check("done_after_h", done_cnt, 3);
        check("idle_after_h", 32'(busy), 0);

        // I/J: fresh capture after reset starts from address 0
        start_v = 20; start_h = 0;
        drive_frame();
        start_v = -1;
        cap_this = 1; seed = 12'hC3C;
        drive_frame();
        cap_this = 0;
        repeat (5) @(negedge clk);
        check("done_after_j", done_cnt, 4);
        check("sb_final_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_capture.md
Name: video_capture

Overview:
Receive-side counterpart of the video generator. It samples a 12-bit RGB plus hsync/vsync stream, and every signal is synchronous to clk. It decimates the active region into a FB_WIDTH x FB_HEIGHT frame and writes that frame into the 16K x 12 video memory through a write port. Uses:
- loopback self-test of the generator;
- capturing an external source into the framebuffer that the generator then displays.

Parameters:
FB_WIDTH, 128, captured columns per row
FB_HEIGHT, 96, captured rows per frame (FB_WIDTH*FB_HEIGHT <= 16384, checked at elaboration)
H_START, 144, clocks from hsync leading edge to first active pixel
V_START, 35, lines from vsync leading edge to first active line
H_DECIM, 5, active clocks per captured column
V_DECIM, 5, active lines per captured row
SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low; 0 = asserted high

Ports:
clk  in  1  system clock (pixel clock)
rst  in  1  asynchronous, active-low reset
capture_start  in  1  single-cycle request to capture the next full frame
video_rgb  in  12  pixel data
video_hsync  in  1  horizontal sync
video_vsync  in  1  vertical sync
wr_addr  out  14  memory write address = row*FB_WIDTH + col
wr_data  out  12  memory write data
wr_en  out  1  write strobe, one word per asserted cycle
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse when capture ends
short_frame  out  1  set when capture ended early; held until the next accepted start

Behaviour:
- Reset value of every output is 0. State is IDLE. All counters and the input registers clear.
- Input stage: rgb, hsync and vsync are registered once (stage 1). The edge detector compares stage 1 against its previous value.
- Leading edge = transition into the asserted level, per SYNC_ACTIVE_LOW.
- Horizontal counter hcnt:
  - cleared to 0 on the cycle the hsync leading edge is detected;
  - otherwise increments, saturating at all-ones (width 12).
- Line counter vcnt:
  - cleared on the vsync leading edge;
  - otherwise increments on each hsync leading edge, saturating.
- Active column: hcnt in [H_START, H_START+FB_WIDTH*H_DECIM).
  - A column is sampled when the decimation phase is 0.
  - The phase counter resets at H_START.
- Active row: vcnt in [V_START, V_START+FB_HEIGHT*V_DECIM), with the line phase equal to 0.
- States:
  - IDLE: capture_start=1 -> ARMED; busy=1; short_frame cleared.
  - ARMED: waits for a vsync leading edge -> CAPTURE (row=0, col=0). capture_start is ignored.
  - CAPTURE: on each sampled active pixel, wr_en=1, wr_data=pixel, wr_addr=row*FB_WIDTH+col, then col++.
    - On a hsync leading edge after a sampled row, row++ and col=0.
    - Writing row FB_HEIGHT-1, col FB_WIDTH-1 -> DONE.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Latency: a pixel present on video_rgb in cycle T appears on wr_data with wr_en=1 in cycle T+2.
- Boundary cases:
  - Short line (hsync arrives before FB_WIDTH columns): the unwritten columns are skipped and the next row starts at row*FB_WIDTH.
  - vsync leading edge in CAPTURE before the frame completes: DONE with short_frame=1, and no further writes.
  - capture_start in DONE or CAPTURE: ignored.
  - capture_start in the same cycle as a vsync edge while IDLE: goes to ARMED only. The capture starts at the next vsync.
  - No sync activity while ARMED: stays ARMED indefinitely, with busy=1.
  - wr_addr never exceeds FB_WIDTH*FB_HEIGHT-1. There is no wrap.
  - rst asserted mid-capture: immediate return to IDLE, and wr_en drops asynchronously. Already-written memory is not restored.

Optional Feature:
VIDEO_CAPTURE_CRC_EN
- Defined:
  - Adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over each written wr_data, taking the 12 bits zero-extended to 16 and MSB first.
  - The CRC is reset to the init value on an accepted start and updated in the wr_en cycle.
  - frame_crc is stable from frame_done until the next accepted start.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package video_pkg:
  - ADDR_W=14, RGB_W=12;
  - default FB_WIDTH/FB_HEIGHT;
  - capture state enum (IDLE, ARMED, CAPTURE, DONE);
  - CRC polynomial and init constants.
- Sub-module video_sync_counter: input register stage, sync edge detect, hcnt/vcnt, and active/phase flags. The top level holds the FSM, address generation and the write port.

Test Plan:
- Generator loopback at 640x480 timing, gradient pattern, start pulse -> exactly 12288 writes; addr 0..12287 in order; wr_data equals the source pixel at hcnt=H_START+5*col, line V_START+5*row; one frame_done.
- Pixel 0xABC driven at the first active sample in cycle T -> wr_en=1, wr_data=0xABC, wr_addr=0 in cycle T+2.
- vsync leading edge after row 40 -> frame_done with short_frame=1, no write beyond addr 40*128+127, busy=0 the next cycle.
- Line cut short after 100 columns on row 3 -> row 3 writes addr 384..483 only; row 4 starts at addr 512.
- rst low during CAPTURE at addr 5000 -> wr_en, busy and frame_done are 0 immediately. After release a new start captures from addr 0.
- With VIDEO_CAPTURE_CRC_EN, constant 0x000 frame captured twice -> identical non-0xFFFF frame_crc; changing one pixel changes frame_crc.
